lw_sha_axi4_wr_queue: RTL

- Parametrised write-admission queue between the AXI4 slave adapter conduit write port and the SHA/HMAC interface control logic.
- Replaces single-cycle reject-on-not-ready gating with an in-order, DEPTH-entry {addr,data} FIFO.
- Entries to the NCH core-gated channels (DIN, KEY, ...) drain only when the matching core ready is high. All other entries drain immediately.
- Adds overflow accounting, flush on abort, and per-queue DMA write requests.

---
 rtl/lw_sha_axi4_wr_queue_if.sv | 25 ++
 rtl/lw_sha_axi4_wr_queue.sv | 114 +++++++++++
 2 files changed

// File: rtl/lw_sha_axi4_wr_queue_if.sv
// Conduit write port and control-logic write port of the SHA/HMAC write queue.
interface lw_sha_axi4_wr_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  con_wr_i;
  logic [ADDR_WIDTH-1:0] con_waddr_i;
  logic [DATA_WIDTH-1:0] con_wdata_i;
  logic                  con_slv_error_o;
  logic                  ctl_wr_o;
  logic [ADDR_WIDTH-1:0] ctl_waddr_o;
  logic [DATA_WIDTH-1:0] ctl_wdata_o;

  // Queue side: receives conduit writes, drives the control logic.
  modport slave (
    input  con_wr_i, con_waddr_i, con_wdata_i,
    output con_slv_error_o, ctl_wr_o, ctl_waddr_o, ctl_wdata_o
  );

  // Adapter/control side.
  modport master (
    output con_wr_i, con_waddr_i, con_wdata_i,
    input  con_slv_error_o, ctl_wr_o, ctl_waddr_o, ctl_wdata_o
  );
endinterface

// File: rtl/lw_sha_axi4_wr_queue.sv
// In-order write-admission FIFO between the AXI4 conduit and SHA/HMAC control.
// Entries addressed to a core-gated channel drain only while that core is
// ready; every younger entry waits behind a stalled head.
module lw_sha_axi4_wr_queue #(
  parameter int                          DATA_WIDTH = 32,
  parameter int                          ADDR_WIDTH = 12,
  parameter int                          DEPTH      = 4,
  parameter int                          NCH        = 2,
  parameter logic [NCH*ADDR_WIDTH-1:0]   CH_ADDR    = {12'h020, 12'h010},
  parameter int                          DMA_BURST  = 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  lw_sha_axi4_wr_queue_if.slave    bus,
  input  logic [NCH-1:0]           ch_ready_i,
  input  logic                     flush_i,
  input  logic                     ovf_clr_i,
  output logic                     ovf_o,
  output logic [7:0]               ovf_cnt_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     dma_wr_req_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0]         wr_ptr_q, rd_ptr_q, level_q, level_nxt;
  logic [NCH-1:0]        block_q, head_ch;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_ok, pop, accept, rej_ovf, rej_any;
  logic [7:0]            cnt_q;

  logic                  ctl_wr_p1, err_p1, ovf_p1, dma_p1;
  logic [ADDR_WIDTH-1:0] ctl_waddr_p1;
  logic [DATA_WIDTH-1:0] ctl_wdata_p1;

  // Head classification and admission/drain decisions for this cycle.
  always_comb begin
    head_addr = addr_mem[rd_ptr_q[AW-1:0]];
    head_data = data_mem[rd_ptr_q[AW-1:0]];
    head_ch   = '0;
    for (int c = 0; c < NCH; c++) begin
      head_ch[c] = (head_addr == CH_ADDR[c*ADDR_WIDTH +: ADDR_WIDTH]);
    end
    // Ungated heads always drain; gated heads need ready and no recent pop.
    head_ok   = (head_ch == '0) || ((head_ch & ch_ready_i & ~block_q) == head_ch);
    pop       = (level_q != '0) && head_ok && !flush_i;
    accept    = bus.con_wr_i && !flush_i && ((level_q < PW'(DEPTH)) || pop);
    rej_ovf   = bus.con_wr_i && !flush_i && !accept;
    rej_any   = bus.con_wr_i && !accept;
    level_nxt = flush_i ? '0 : (level_q + PW'(accept) - PW'(pop));
  end

  // Storage array: written on every accepted conduit write.
  always_ff @(posedge aclk) begin
    if (accept) begin
      addr_mem[wr_ptr_q[AW-1:0]] <= bus.con_waddr_i;
      data_mem[wr_ptr_q[AW-1:0]] <= bus.con_wdata_i;
    end
  end

  // Pointers, occupancy, channel block flags, overflow accounting, outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      block_q      <= '0;
      cnt_q        <= '0;
      ctl_wr_p1    <= 1'b0;
      ctl_waddr_p1 <= '0;
      ctl_wdata_p1 <= '0;
      err_p1       <= 1'b0;
      ovf_p1       <= 1'b0;
      dma_p1       <= 1'b1;
    end else begin
      if (flush_i) begin
        rd_ptr_q <= wr_ptr_q;
      end else begin
        if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      level_q <= level_nxt;
      // A channel pop blocks that channel for one cycle while the core's
      // ready has not yet fallen.
      block_q <= pop ? head_ch : '0;

      if (ovf_clr_i)                    cnt_q <= {7'd0, rej_ovf};
      else if (rej_ovf && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;

      // ---- stage p1: registered outputs of this cycle's decisions ----
      ctl_wr_p1 <= pop;
      if (pop) begin
        ctl_waddr_p1 <= head_addr;
        ctl_wdata_p1 <= head_data;
      end
      err_p1 <= rej_any;
      ovf_p1 <= rej_ovf;
      dma_p1 <= (PW'(DEPTH) - level_nxt) >= PW'(DMA_BURST);
    end
  end

  assign bus.ctl_wr_o        = ctl_wr_p1;
  assign bus.ctl_waddr_o     = ctl_waddr_p1;
  assign bus.ctl_wdata_o     = ctl_wdata_p1;
  assign bus.con_slv_error_o = err_p1;
  assign ovf_o               = ovf_p1;
  assign ovf_cnt_o           = cnt_q;
  assign level_o             = level_q;
  assign dma_wr_req_o        = dma_p1;
endmodule
